// File: rtl/stream_window_framer.sv
// stream_window_framer: triggered capture into a circular buffer, replayed as overlapping windows
// through a registered output stage with a one-entry skid.
module stream_window_framer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WINDOW  = 512,
  parameter int unsigned STEP    = 160,
  parameter int unsigned NFRAMES = 97,
  parameter int unsigned DEPTH   = 1024,
  localparam int unsigned FW     = (NFRAMES > 1) ? $clog2(NFRAMES) : 1
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              trigger,
  input  logic              abort,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [FW-1:0]     m_frame,
  output logic              active,
  output logic              done,
  output logic              overflow
);
  localparam int unsigned TOTAL = WINDOW + (NFRAMES - 1) * STEP;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW    = DATA_W + 1 + FW;

  if (DEPTH < WINDOW || (DEPTH & (DEPTH - 1)) != 0 || STEP < 1 || STEP > WINDOW) begin : g_bad_params
    $error("stream_window_framer: illegal DEPTH/WINDOW/STEP combination");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     wcnt_q, wcnt_d, base_q, base_d, rcnt_q, rcnt_d, rbase_q, rbase_d, occ;
  logic [FW-1:0]     rframe_q, rframe_d;
  logic              rdone_q, rdone_d, rd_v_q, rd_v_d, head_v_q, head_v_d, skid_v_q, skid_v_d;
  logic              ovf_q, ovf_d, done_q, done_d;
  logic [FW:0]       rd_tag_q, rd_tag_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [EW-1:0]     rd_e, head_q, head_d, skid_q, skid_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              run, in_win, wr_en, hs, r_last, r_final, issue;
  logic [1:0]        inflight;

  assign occ      = wcnt_q - base_q;
  assign run      = (state_q == RUN) && !abort;
  assign in_win   = run && s_valid && (wcnt_q < CW'(TOTAL));
  assign wr_en    = in_win && (32'(occ) < DEPTH);
  assign hs       = head_v_q && m_ready;
  assign r_last   = rcnt_q == rbase_q + CW'(WINDOW - 1);
  assign r_final  = r_last && (rframe_q == FW'(NFRAMES - 1));
  // Read stage plus two output slots: issuing only while fewer than two are committed keeps the skid from overrunning.
  assign inflight = 2'(rd_v_q) + 2'(head_v_q) + 2'(skid_v_q);
  assign issue    = run && !rdone_q && (rcnt_q < wcnt_q) && (inflight < 2'd2 || (hs && inflight == 2'd2));
  assign rd_e     = {rd_data_q, rd_tag_q};

  assign {m_data, m_last, m_frame} = head_q;
  assign m_valid  = head_v_q;
  assign active   = state_q == RUN;
  assign done     = done_q;
  assign overflow = ovf_q;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    base_d   = base_q;
    rcnt_d   = rcnt_q;
    rbase_d  = rbase_q;
    rframe_d = rframe_q;
    rdone_d  = rdone_q;
    rd_v_d   = rd_v_q;
    rd_tag_d = rd_tag_q;
    head_v_d = head_v_q;
    head_d   = head_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (trigger && !abort) begin
        state_d  = RUN;
        wcnt_d   = '0;
        base_d   = '0;
        rcnt_d   = '0;
        rbase_d  = '0;
        rframe_d = '0;
        rdone_d  = 1'b0;
        ovf_d    = 1'b0;
      end
    end else if (abort) begin
      state_d  = IDLE;
      rd_v_d   = 1'b0;
      head_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      wcnt_d   = wr_en ? wcnt_q + CW'(1) : wcnt_q;
      ovf_d    = ovf_q | (in_win & ~wr_en);
      rd_v_d   = issue;
      rd_tag_d = issue ? {r_last, rframe_q} : rd_tag_q;
      if (issue && r_last) begin
        rdone_d  = r_final;
        rbase_d  = r_final ? rbase_q : rbase_q + CW'(STEP);
        rcnt_d   = r_final ? rcnt_q : rbase_q + CW'(STEP);
        rframe_d = r_final ? rframe_q : rframe_q + FW'(1);
      end else if (issue) begin
        rcnt_d = rcnt_q + CW'(1);
      end
      if (hs) begin
        head_d   = skid_v_q ? skid_q : rd_e;
        head_v_d = skid_v_q | rd_v_q;
        skid_d   = rd_e;
        skid_v_d = skid_v_q & rd_v_q;
      end else if (!head_v_q) begin
        head_d   = rd_e;
        head_v_d = rd_v_q;
      end else if (rd_v_q) begin
        skid_d   = rd_e;
        skid_v_d = 1'b1;
      end
      // The write window only slides once the consumer has taken a frame's last sample.
      if (hs && m_last) begin
        base_d = base_q + CW'(STEP);
        if (m_frame == FW'(NFRAMES - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      base_q   <= '0;
      rcnt_q   <= '0;
      rbase_q  <= '0;
      rframe_q <= '0;
      rdone_q  <= 1'b0;
      rd_v_q   <= 1'b0;
      rd_tag_q <= '0;
      head_v_q <= 1'b0;
      head_q   <= '0;
      skid_v_q <= 1'b0;
      skid_q   <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      base_q   <= base_d;
      rcnt_q   <= rcnt_d;
      rbase_q  <= rbase_d;
      rframe_q <= rframe_d;
      rdone_q  <= rdone_d;
      rd_v_q   <= rd_v_d;
      rd_tag_q <= rd_tag_d;
      head_v_q <= head_v_d;
      head_q   <= head_d;
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[AW'(wcnt_q)] <= s_data;
    if (issue) rd_data_q <= mem[AW'(rcnt_q)];
  end
endmodule

// File: tb/tb_stream_window_framer.sv
// tb_stream_window_framer: random stimulus against a frame/index reference model of the window framer.
module tb_stream_window_framer;
  localparam int W = 8, S = 4, NF = 3, D = 16, TOT = 16;

  logic        clk, arstn, trigger, abort, s_valid, m_ready;
  logic [31:0] s_data, m_data, d8;
  logic        m_valid, m_last, active, done, overflow;
  logic        v8, l8, a8, dn8, o8;
  logic [1:0]  m_frame, f8;

  stream_window_framer #(.DATA_W(32), .WINDOW(W), .STEP(S), .NFRAMES(NF), .DEPTH(D)) u_dut (
    .clk(clk), .arstn(arstn), .trigger(trigger), .abort(abort), .s_data(s_data), .s_valid(s_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_frame(m_frame),
    .active(active), .done(done), .overflow(overflow));

  stream_window_framer #(.DATA_W(32), .WINDOW(W), .STEP(S), .NFRAMES(NF), .DEPTH(8)) u_dut8 (
    .clk(clk), .arstn(arstn), .trigger(trigger), .abort(abort), .s_data(s_data), .s_valid(s_valid),
    .m_data(d8), .m_valid(v8), .m_ready(m_ready), .m_last(l8), .m_frame(f8),
    .active(a8), .done(dn8), .overflow(o8));

  int          n_chk = 0, n_pass = 0, cyc = 0, rdy_mode = 1;
  bit          running, movf, exp_done, prev_stall, hs_m, nd;
  int          mw, mbase, opos, idx;
  logic [31:0] mdat [TOT];
  int          wr_edge [TOT];
  logic [63:0] held;
  logic [31:0] sent [9];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 m_ready = (rdy_mode == 2) ? 1'($urandom_range(1)) : (rdy_mode == 1);
    end
  end

  // Reference: window f covers sample indices f*S .. f*S+W-1; output position opos maps to one of them.
  always @(negedge clk) begin
    if (!arstn) begin
      running = 0; movf = 0; exp_done = 0; prev_stall = 0; mw = 0; mbase = 0; opos = 0;
    end else begin
      chk("active", 64'(active), 64'(running));
      chk("done", 64'(done), 64'(exp_done));
      chk("overflow", 64'(overflow), 64'(movf));
      if (!running) chk("idle_valid", 64'(m_valid), 64'(0));
      if (prev_stall) begin
        chk("hold_valid", 64'(m_valid), 64'(1));
        chk("hold_data", {29'b0, m_data, m_last, m_frame}, held);
      end
      idx = (opos / W) * S + opos % W;
      hs_m = running && m_valid && m_ready;
      if (running && m_valid && !prev_stall)
        chk("latency", 64'((idx < mw) && (cyc >= wr_edge[idx] + 2)), 64'(1));
      if (hs_m) begin
        chk("data", 64'(m_data), 64'(mdat[idx]));
        chk("last", 64'(m_last), 64'(opos % W == W - 1));
        chk("frame", 64'(m_frame), 64'(opos / W));
      end
      prev_stall = running && !abort && m_valid && !m_ready;
      held = {29'b0, m_data, m_last, m_frame};
      nd = 0;
      if (running && abort) running = 0;
      else if (running) begin
        if (s_valid && mw < TOT) begin
          if (mw - mbase < D) begin
            mdat[mw] = s_data; wr_edge[mw] = cyc + 1; mw++;
          end else movf = 1;
        end
        if (hs_m) begin
          if (opos % W == W - 1) mbase += S;
          opos++;
          if (opos == NF * W) begin running = 0; nd = 1; end
        end
      end else if (trigger && !abort) begin
        running = 1; mw = 0; mbase = 0; opos = 0; movf = 0;
      end
      exp_done = nd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    abort = 1; tick(); abort = 0;
    trigger = 1; tick(); trigger = 0;
  endtask

  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      s_valid = 1; s_data = $urandom; tick();
      s_valid = 0;
      if (gaps) repeat ($urandom_range(1)) tick();
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget && running; c++) tick();
    chk("idle_wait", 64'(running), 64'(0));
  endtask

  task automatic rst_chk();
    chk("rst_valid", 64'(m_valid), 64'(0));
    chk("rst_data", 64'(m_data), 64'(0));
    chk("rst_last", 64'(m_last), 64'(0));
    chk("rst_frame", 64'(m_frame), 64'(0));
    chk("rst_active", 64'(active), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
  endtask

  initial begin
    int got;
    arstn = 1; trigger = 0; abort = 0; s_valid = 0; s_data = 0;
    #1 arstn = 0;
    #1 rst_chk();
    @(posedge clk); #2 arstn = 1;
    // back-to-back, always ready
    rdy_mode = 1; start(); feed(16, 0); wait_idle(100);
    chk("t1_outputs", 64'(opos), 64'(NF * W));
    // random ready and gapped source
    rdy_mode = 2; start(); feed(16, 1); wait_idle(300);
    chk("t2_outputs", 64'(opos), 64'(NF * W));
    // overflow on the 8-deep instance while the consumer is stalled
    rdy_mode = 0; start();
    for (int i = 0; i < 9; i++) begin
      s_valid = 1; s_data = $urandom; sent[i] = s_data; tick();
    end
    s_valid = 0; tick(); tick();
    chk("t3_ovf8", 64'(o8), 64'(1));
    rdy_mode = 1; got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      if (v8 && m_ready) begin
        chk("t3_data8", 64'(d8), 64'(sent[got]));
        chk("t3_last8", 64'(l8), 64'(got == 7));
        chk("t3_frame8", 64'(f8), 64'(0));
        got++;
      end
    end
    chk("t3_count8", 64'(got), 64'(8));
    // abort during frame 1, then restart
    rdy_mode = 1; start(); feed(10, 0);
    for (int c = 0; c < 50 && opos < 12; c++) tick();
    chk("t4_reach_f1", 64'(opos >= 12 && opos < 16), 64'(1));
    abort = 1; tick(); abort = 0;
    @(negedge clk);
    chk("t4_abort_valid", 64'(m_valid), 64'(0));
    chk("t4_abort_active", 64'(active), 64'(0));
    repeat (3) tick();
    start();
    chk("t4_ovf8_clear", 64'(o8), 64'(0));
    feed(16, 0); wait_idle(100);
    chk("t4_outputs", 64'(opos), 64'(NF * W));
    // idle samples, trigger while running, surplus samples
    rdy_mode = 2;
    s_valid = 1;
    repeat (3) begin s_data = $urandom; tick(); end
    s_valid = 0;
    start(); feed(8, 1);
    trigger = 1; tick(); trigger = 0;
    feed(12, 1); wait_idle(300);
    chk("t5_outputs", 64'(opos), 64'(NF * W));
    chk("t5_ovf", 64'(overflow), 64'(0));
    // asynchronous reset mid-frame, then a clean run
    rdy_mode = 1; start(); feed(16, 0);
    @(posedge clk); #2 arstn = 0;
    #1 rst_chk();
    repeat (2) @(posedge clk);
    #2 arstn = 1;
    start(); feed(16, 0); wait_idle(100);
    chk("t6_outputs", 64'(opos), 64'(NF * W));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
